// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: word width, R-type funct codes and
// the multiply/divide FSM state encoding.
package mips_pkg;

  localparam int unsigned N     = 31;
  localparam int unsigned W     = N + 1;
  localparam int unsigned CNT_W = $clog2(W);

  // ALU R-type functs
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Multiply/divide functs
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;
  import mips_pkg::*;

  logic         start;
  logic         flush;
  logic [5:0]   funct;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, flush, funct, A, B,
    input  busy, done, result, hi, lo
  );

  modport slave (
    input  start, flush, funct, A, B,
    output busy, done, result, hi, lo
  );

endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Final sign correction of the shared accumulator into HI/LO values
// for both the product and the remainder:quotient layouts.
module sign_fix
  import mips_pkg::*;
(
  input  logic           is_div,
  input  logic           neg_res,
  input  logic           neg_rem,
  input  logic           div0,
  input  logic [2*W-1:0] acc,
  output logic [W-1:0]   hi_c,
  output logic [W-1:0]   lo_c
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[W-1:0] : acc[W-1:0];
    rem  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
    if (is_div) begin
      // Remainder of |A|/0 is |A|, so with the dividend sign HI comes back as A.
      hi_c = rem;
      lo_c = div0 ? '1 : quo;
    end else begin
      hi_c = prod[2*W-1:W];
      lo_c = prod[W-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shared 2W-bit accumulator holds the product or remainder:quotient.
module mul_div_unit
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mul_div_unit_if.slave bus
);

  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           is_div_q, is_div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           signed_op;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_cand;
  logic [W+1:0]   div_diff;
  logic           div_take;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] div_next;
  logic [W-1:0]   fix_hi_c, fix_lo_c;

  // Operand magnitudes and sign flags for a new issue
  always_comb begin
    signed_op = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    a_neg     = signed_op & bus.A[N];
    b_neg     = signed_op & bus.B[N];
    a_mag     = a_neg ? -bus.A : bus.A;
    b_mag     = b_neg ? -bus.B : bus.B;
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : (W+1)'(0));
    mul_next = {mul_sum, acc_q[W-1:1]};

    div_cand = acc_q[2*W-1:W-1];
    div_diff = {1'b0, div_cand} - {2'b00, b_q};
    div_take = ~div_diff[W+1];
    div_rem  = div_take ? div_diff[W-1:0] : div_cand[W-1:0];
    div_next = {div_rem, acc_q[W-2:0], div_take};
  end

  sign_fix u_sign_fix (
    .is_div  (is_div_q),
    .neg_res (neg_res_q),
    .neg_rem (neg_rem_q),
    .div0    (div0_q),
    .acc     (acc_q),
    .hi_c    (fix_hi_c),
    .lo_c    (fix_lo_c)
  );

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.funct == F_MTHI) begin
            hi_d = bus.A;
          end else if (bus.funct == F_MTLO) begin
            lo_d = bus.A;
          end else if (is_muldiv(bus.funct)) begin
            state_d   = ST_CALC;
            cnt_d     = '0;
            acc_d     = {W'(0), a_mag};
            b_d       = b_mag;
            is_div_d  = bus.funct[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = bus.funct[1] & (bus.B == '0);
          end
        end
      end
      ST_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        hi_d    = fix_hi_c;
        lo_d    = fix_lo_c;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides any issue or completion on this edge
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = (bus.funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It sits beside the ALU and takes the same A/B operands from the ID/EX register. It handles the R-type functs the ALU does not: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO. Its `result` is muxed with the ALU `result` on the way to EX/MEM, and its `busy` drives the pipeline stall logic.

## Interface
- `N`, 31: datapath MSB index, so the word width is N+1 bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe, sampled each rising edge.
- `flush`  in  1  aborts an in-flight operation.
- `funct`  in  6  R-type funct field.
- `A`  in  N+1  rs operand.
- `B`  in  N+1  rt operand.
- `busy`  out  1  operation in flight; stall EX.
- `done`  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- `result`  out  N+1  HI when funct=MFHI, else LO (combinational).
- `hi`  out  N+1  HI register.
- `lo`  out  N+1  LO register.

## Operation
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- FSM states IDLE, CALC, FIX.
  - IDLE→CALC: on `start`, with MULT/MULTU/DIV/DIVU and not busy. Latch op, signedness, |A|, |B| (magnitudes only for signed ops), sign flags; step counter := 0.
  - CALC: one radix-2 step per cycle (shift-add multiply, restoring divide). Counter increments; at count=N the next state is FIX.
  - FIX: apply sign correction, write HI/LO, pulse `done`, then return to IDLE.
- MTHI/MTLO with `start` in IDLE: write `A` into HI/LO at that edge. No busy, no done.
- `start` with any other funct, or while busy: ignored.
- MULT/MULTU: {HI,LO} = full 2(N+1)-bit product. For signed, negate the product iff the operand signs differ.
- DIV/DIVU:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
- Divide by zero (B=0, DIV or DIVU): LO=all ones, HI=A unchanged. Still takes full latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- `flush`: has priority over everything. Go to IDLE next edge; HI/LO untouched; no done. A `start` on the same edge as `flush` is ignored.
- Reset: state IDLE, HI=0, LO=0, busy=0, done=0, counter=0.

## Timing
- Start accepted at edge k. `busy`=1 from after edge k through edge k+33.
  - CALC: N+1 = 32 cycles.
  - FIX: 1 cycle.
- HI/LO updated at edge k+33. `done`=1 for exactly the cycle following edge k+33; `busy`=0 in that same cycle.
- Back-to-back: a new `start` may be accepted at edge k+34, i.e. while `done` is high.
- `result`/`hi`/`lo` are combinational from the registers, so MFHI/MFLO issued in the `done` cycle sees the new values.
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after the issue edge.
- `busy` is registered; no combinational path from `start` to `busy`.

## Structure
- Shared package `mips_pkg`:
  - funct localparams for the ALU and this block.
  - FSM state encoding.
  - word-width constant.
- Single module. The 2(N+1)-bit accumulator is shared between multiply (product) and divide (remainder:quotient) to keep the RTL within 120-400 lines.
- No sub-module required. If the sign logic is split out, name it `sign_fix`.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → after 33 busy cycles, HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- MULT A=0xFFFFFFFD (−3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=0x00000007.
- MTHI A=0x12345678, then MFHI → `result`=0x12345678 next cycle. A second MULT `start` 5 cycles into a MULT → ignored; `done` occurs only at cycle 33 of the first operation.
- `flush` at CALC cycle 10 → IDLE next cycle, HI/LO hold prior values, no `done`. `rst_n` low mid-operation → HI=LO=0, busy=0 immediately (asynchronous).
